axis_tlast_packetizer: RTL
==========================

Name: axis_tlast_packetizer

Overview:
- Downstream stage of the AXIS processor wrapper; consumes its master stream and feeds the DMA S2MM channel.
- Frames the output into bounded packets by asserting m_tlast on an upstream tlast or when a beat count reaches MAX_BEATS.
- Provides a 2-entry skid buffer, so s_tready is fully registered and timing is broken between processor and DMA.

Parameters:
- TDATA_WIDTH_BYTES, 4, bytes per beat; tkeep width equals this value.
- MAX_BEATS, 256, maximum beats per packet; legal range 1..65535.
- TIMEOUT_CYCLES, 1024, idle cycles before a terminating null beat is sent; used only with the optional feature.

Ports:
- clk  input  1  single clock for the block.
- arstn  input  1  asynchronous, active-low reset.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  upstream ready; registered.
- s_tdata  input  TDATA_WIDTH_BYTES*8  upstream data.
- s_tkeep  input  TDATA_WIDTH_BYTES  upstream byte enables.
- s_tlast  input  1  upstream end of packet.
- m_tvalid  output  1  downstream beat valid.
- m_tready  input  1  downstream ready.
- m_tdata  output  TDATA_WIDTH_BYTES*8  downstream data.
- m_tkeep  output  TDATA_WIDTH_BYTES  downstream byte enables.
- m_tlast  output  1  downstream end of packet.
- pkt_count  output  32  count of packets completed; wraps modulo 2^32.

Behaviour:
- Reset (arstn low, asynchronous):
  - m_tvalid=0, m_tdata=0, m_tkeep=0, m_tlast=0, s_tready=0, pkt_count=0.
  - Beat counter=0; both buffer entries invalid.
  - s_tready rises on the first clk edge after arstn deasserts.
- Handshakes:
  - A beat transfers when valid and ready are both high at a rising clk edge.
  - m_tvalid never depends combinationally on m_tready.
  - Once m_tvalid is asserted, m_tdata, m_tkeep and m_tlast stay stable until the transfer.
- Skid buffer:
  - Output register plus one skid register.
  - s_tready is registered high when the skid entry is empty.
  - Latency is 1 cycle from s transfer to m_tvalid when the buffer is empty.
  - Sustains 1 beat/cycle throughput when m_tready stays high.
- Framing:
  - tlast is computed on the input side and stored with the beat: tlast_in = s_tlast OR (beat_cnt == MAX_BEATS-1).
  - beat_cnt increments on each accepted beat and clears to 0 on a beat with tlast_in=1.
  - Width of beat_cnt is clog2(MAX_BEATS+1).
  - MAX_BEATS=1 makes every beat carry tlast.
- pkt_count increments on each m-side transfer with m_tlast=1.
- Data and tkeep pass through unmodified; tkeep=0 beats are forwarded as-is.
- Simultaneous events:
  - Input acceptance and output drain in the same cycle keep occupancy constant; no bubble is inserted.
  - Skid full with m_tready low: s_tready=0 on the next cycle; no beat is dropped or duplicated.
- Reset mid-packet: buffered beats are discarded and beat_cnt cleared; the next accepted beat starts a new packet.

Optional Feature:
- Macro: AXIS_TLAST_PACKETIZER_TIMEOUT_EN.
- Defined:
  - An idle counter runs while a packet is open (beat_cnt != 0) and both buffer entries are empty.
  - It clears on any s-side transfer.
  - When it reaches TIMEOUT_CYCLES, the block injects one null beat: tdata=0, tkeep=0, tlast=1.
  - beat_cnt clears and pkt_count increments on the null beat's transfer.
  - s_tready is held low from injection until the null beat transfers.
- Undefined: no idle counter; an open packet stays open indefinitely.

Decomposition:
- Package axis_tlast_packetizer_pkg holds:
  - function clog2_beats;
  - typedef beat_t {data, keep, last};
  - localparam constants NULL_KEEP=0 and PKT_CNT_W=32.
- One natural sub-module: axis_skid_buffer, a generic 2-entry register slice parameterized by payload width.
- The top level adds the beat counter, the tlast merge and the timeout logic.

Test Plan:
- MAX_BEATS=4, continuous 10 beats with s_tlast=0 and m_tready=1 -> m_tlast high on beats 4 and 8; pkt_count=2; beat 10 carries no tlast; 1 beat/cycle throughput.
- MAX_BEATS=256, 3 beats with s_tlast on beat 3 -> m_tlast on beat 3; next packet's beat_cnt restarts, checked by a later MAX_BEATS boundary at beat 259.
- Backpressure: m_tready toggled in a pseudo-random 30% pattern over 1000 beats -> s_tready low within 2 cycles of stall; output sequence bit-identical to input; no stable-data violation while m_tvalid=1.
- arstn asserted mid-packet after 2 of 4 beats, with a beat held in the skid -> all outputs 0 asynchronously; after release, a fresh 4-beat sequence yields m_tlast on its 4th beat.
- With TIMEOUT_EN and TIMEOUT_CYCLES=16: send 2 beats, then idle -> after 16 idle cycles a beat with tdata=0, tkeep=0, tlast=1 appears; pkt_count increments by 1.
- With TIMEOUT_EN: an input beat arriving on idle cycle 15 -> counter clears and no null beat is injected.

Source files
------------

// File: rtl/axis_tlast_packetizer_pkg.sv
// axis_tlast_packetizer_pkg: shared types, constants and helpers for the tlast packetizer.
package axis_tlast_packetizer_pkg;

    localparam int PKT_CNT_W  = 32;
    localparam int NULL_KEEP  = 0;
    localparam int BEAT_BYTES = 4;

    typedef struct packed {
        logic [BEAT_BYTES*8-1:0] data;
        logic [BEAT_BYTES-1:0]   keep;
        logic                    last;
    } beat_t;

    typedef enum logic [1:0] {TO_RUN, TO_INJ, TO_WAIT} to_state_t;

    function automatic int clog2_beats(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/axis_tlast_packetizer_skid.sv
// axis_skid_buffer: generic 2-entry register slice (output register plus skid register) with registered ready.
module axis_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid, skid_nxt, in_fire, load;
    logic [W-1:0] skid_data;

    assign in_fire  = in_valid & in_ready;
    assign load     = !out_valid || out_ready;
    assign skid_nxt = !load && (skid_valid || in_fire);

    // Output register refills from the skid first; the skid only catches a beat while the output is stalled.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            in_ready   <= !skid_nxt;
            skid_valid <= skid_nxt;
            if (load) begin
                out_valid <= skid_valid || in_fire;
                out_data  <= skid_valid ? skid_data : in_data;
            end
            if (!load && in_fire) skid_data <= in_data;
        end
    end

endmodule

// File: rtl/axis_tlast_packetizer.sv
// axis_tlast_packetizer: frames an AXI-Stream into packets of at most MAX_BEATS beats behind a 2-entry skid buffer.
// Define AXIS_TLAST_PACKETIZER_TIMEOUT_EN to close an idle open packet with a null tlast beat after TIMEOUT_CYCLES.
module axis_tlast_packetizer
    import axis_tlast_packetizer_pkg::*;
#(
    parameter int TDATA_WIDTH_BYTES = 4,
    parameter int MAX_BEATS         = 256,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                           clk,
    input  logic                           arstn,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic [TDATA_WIDTH_BYTES*8-1:0] s_tdata,
    input  logic [TDATA_WIDTH_BYTES-1:0]   s_tkeep,
    input  logic                           s_tlast,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [TDATA_WIDTH_BYTES*8-1:0] m_tdata,
    output logic [TDATA_WIDTH_BYTES-1:0]   m_tkeep,
    output logic                           m_tlast,
    output logic [PKT_CNT_W-1:0]           pkt_count
);

    localparam int DW = TDATA_WIDTH_BYTES * 8;
    localparam int PW = DW + TDATA_WIDTH_BYTES + 1;
    localparam int CW = clog2_beats(MAX_BEATS);

    if (MAX_BEATS < 1 || MAX_BEATS > 65535 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axis_tlast_packetizer: illegal MAX_BEATS or TIMEOUT_CYCLES");
    end

    logic [CW-1:0] beat_cnt;
    logic [PW-1:0] in_payload, out_payload;
    logic          sb_ready, sb_valid, s_fire, m_fire, tlast_in, inj, hold, null_done;

    assign s_tready   = sb_ready & ~hold;
    assign s_fire     = s_tvalid & s_tready;
    assign m_fire     = m_tvalid & m_tready;
    assign tlast_in   = s_tlast | (beat_cnt == CW'(MAX_BEATS - 1));
    assign sb_valid   = inj | (s_tvalid & ~hold);
    assign in_payload = inj ? {{DW{1'b0}}, TDATA_WIDTH_BYTES'(NULL_KEEP), 1'b1}
                            : {s_tdata, s_tkeep, tlast_in};
    assign {m_tdata, m_tkeep, m_tlast} = out_payload;

    axis_skid_buffer #(.W(PW)) u_skid (
        .clk      (clk),
        .arstn    (arstn),
        .in_valid (sb_valid),
        .in_ready (sb_ready),
        .in_data  (in_payload),
        .out_valid(m_tvalid),
        .out_ready(m_tready),
        .out_data (out_payload)
    );

    // Beat position within the open packet; restarts after any beat that closes a packet.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) beat_cnt <= '0;
        else if (s_fire) beat_cnt <= tlast_in ? '0 : beat_cnt + 1'b1;
        else if (null_done) beat_cnt <= '0;
    end

    // Completed packets, counted where they leave the block.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) pkt_count <= '0;
        else if (m_fire && m_tlast) pkt_count <= pkt_count + 1'b1;
    end

`ifdef AXIS_TLAST_PACKETIZER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    to_state_t     state, state_nxt;
    logic [IW-1:0] idle_cnt;
    logic          idle, expire;

    assign idle   = (beat_cnt != '0) && !m_tvalid && (state == TO_RUN);
    assign expire = idle && !s_fire && (idle_cnt == IW'(TIMEOUT_CYCLES - 1));

    // Consecutive cycles an open packet has sat with an empty buffer.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) idle_cnt <= '0;
        else idle_cnt <= (idle && !s_fire) ? idle_cnt + 1'b1 : '0;
    end

    // Timeout state register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) state <= TO_RUN;
        else state <= state_nxt;
    end

    // Inject one null beat on expiry and block the input until it has left the block.
    always_comb begin
        state_nxt = (state == TO_RUN) ? (expire ? TO_INJ : TO_RUN)
                  : (state == TO_INJ) ? (sb_ready ? TO_WAIT : TO_INJ)
                  : (m_fire ? TO_RUN : TO_WAIT);
        inj       = (state == TO_INJ);
        hold      = (state != TO_RUN);
        null_done = (state == TO_WAIT) && m_fire;
    end
`else
    assign inj       = 1'b0;
    assign hold      = 1'b0;
    assign null_done = 1'b0;
`endif

endmodule
